// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller in front of the ALU function units (arith, logic, cmp, shift).
// Optional back-to-back issue from DONE is enabled by defining ALU_ISSUE_B2B_EN.
//
// state | meaning
// IDLE  | ready for a new op, in_ready high
// ISSUE | one-hot enable to the selected unit for one cycle
// CAPT  | unit result is registered; captured at the closing edge
// DONE  | result held on out_* until out_ready
module alu_issue_ctrl #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_A,
  input  logic [width-1:0] in_B,
  input  logic [3:0]       in_fun,
  output logic [width-1:0] A,
  output logic [width-1:0] B,
  output logic [1:0]       ALU_FUN,
  output logic             arith_enable,
  output logic             logic_enable,
  output logic             cmp_enable,
  output logic             shift_enable,
  input  logic [width-1:0] arith_out,
  input  logic             arith_flag,
  input  logic [width-1:0] logic_out,
  input  logic             logic_flag,
  input  logic [width-1:0] cmp_out,
  input  logic             cmp_flag,
  input  logic [width-1:0] shift_out,
  input  logic             shift_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_flag,
  output logic [1:0]       out_unit
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       fun_q, fun_d, sel_q, sel_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_flag_q, out_flag_d;
  logic [1:0]       out_unit_q, out_unit_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic [width-1:0] mux_data;
  logic             mux_flag;

  always_comb begin
`ifdef ALU_ISSUE_B2B_EN
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
    in_ready = (state_q == IDLE);
`endif
    accept = in_valid && in_ready;
  end

  always_comb begin
    unique case (sel_q)
      2'b00:   begin mux_data = arith_out; mux_flag = arith_flag; end
      2'b01:   begin mux_data = logic_out; mux_flag = logic_flag; end
      2'b10:   begin mux_data = cmp_out;   mux_flag = cmp_flag;   end
      default: begin mux_data = shift_out; mux_flag = shift_flag; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_flag_d  = out_flag_q;
    out_unit_d  = out_unit_q;
    out_valid_d = out_valid_q;
    // accept can only be true in IDLE, or in DONE alongside a consume
    if (accept) begin
      a_d   = in_A;
      b_d   = in_B;
      fun_d = in_fun[1:0];
      sel_d = in_fun[3:2];
    end
    unique case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: state_d = CAPT;
      CAPT: begin
        out_data_d  = mux_data;
        out_flag_d  = mux_flag;
        out_unit_d  = sel_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = accept ? ISSUE : IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_flag_q  <= 1'b0;
      out_unit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_flag_q  <= out_flag_d;
      out_unit_q  <= out_unit_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    arith_enable = (state_q == ISSUE) && (sel_q == 2'b00);
    logic_enable = (state_q == ISSUE) && (sel_q == 2'b01);
    cmp_enable   = (state_q == ISSUE) && (sel_q == 2'b10);
    shift_enable = (state_q == ISSUE) && (sel_q == 2'b11);
  end

  assign A         = a_q;
  assign B         = b_q;
  assign ALU_FUN   = fun_q;
  assign out_data  = out_data_q;
  assign out_flag  = out_flag_q;
  assign out_unit  = out_unit_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with simple registered function-unit models.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_A = '0, in_B = '0;
  logic [3:0]  in_fun = '0;
  logic [15:0] A, B;
  logic [1:0]  ALU_FUN;
  logic        arith_enable, logic_enable, cmp_enable, shift_enable;
  logic [15:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic        arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_flag;
  logic [1:0]  out_unit;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.width(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_fun(in_fun),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .arith_out(arith_out), .arith_flag(arith_flag),
    .logic_out(logic_out), .logic_flag(logic_flag),
    .cmp_out(cmp_out), .cmp_flag(cmp_flag),
    .shift_out(shift_out), .shift_flag(shift_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flag(out_flag), .out_unit(out_unit)
  );

  // Unit models: register a result only while enabled, hold otherwise.
  always @(posedge clk) begin
    if (arith_enable) begin
      {arith_flag, arith_out} <= (ALU_FUN == 2'b01) ? ({1'b0, A} - {1'b0, B}) : ({1'b0, A} + {1'b0, B});
    end
    if (logic_enable) begin
      case (ALU_FUN)
        2'b00:   begin logic_out <= A & B;    logic_flag <= |(A & B);    end
        2'b01:   begin logic_out <= A | B;    logic_flag <= |(A | B);    end
        2'b10:   begin logic_out <= A ^ B;    logic_flag <= |(A ^ B);    end
        default: begin logic_out <= ~(A | B); logic_flag <= |(~(A | B)); end
      endcase
    end
    if (cmp_enable) begin
      cmp_out  <= (A < B) ? 16'd1 : 16'd0;
      cmp_flag <= (A == B);
    end
    if (shift_enable) begin
      shift_out  <= A << B[3:0];
      shift_flag <= |(A << B[3:0]);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ens();
    return {arith_enable, logic_enable, cmp_enable, shift_enable};
  endfunction

  // Issue one op from IDLE and walk it to DONE, checking each state on the way.
  task automatic run_op(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
    logic [3:0] onehot;
    onehot = 4'b1000 >> fun[3:2];
    in_valid = 1'b1; in_fun = fun; in_A = a; in_B = b;
    check("idle_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_A = ~a; in_B = ~b; in_fun = ~fun;
    check("issue_enables", ens(), onehot);
    check("issue_in_ready", in_ready, 1'b0);
    check("issue_A", A, a);
    check("issue_B", B, b);
    check("issue_fun", ALU_FUN, fun[1:0]);
    check("issue_out_valid", out_valid, 1'b0);
    step();
    check("capt_enables", ens(), 4'b0000);
    check("capt_A", A, a);
    check("capt_out_valid", out_valid, 1'b0);
    step();
    check("done_out_valid", out_valid, 1'b1);
    check("done_enables", ens(), 4'b0000);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consume_out_valid", out_valid, 1'b0);
    check("consume_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    int acc[$];
    int period;
    logic [15:0] held;

`ifdef ALU_ISSUE_B2B_EN
    period = 3;
`else
    period = 4;
`endif

    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_enables", ens(), 4'b0000);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_A", A, 16'h0000);
    step();
    reset = 1'b1;
    step();

    run_op(4'b0101, 16'h00F0, 16'h0F0F);
    check("or_data", out_data, 16'h0FFF);
    check("or_flag", out_flag, 1'b1);
    check("or_unit", out_unit, 2'b01);
    consume();

    run_op(4'b0111, 16'h0000, 16'h0000);
    check("nor_data", out_data, 16'hFFFF);
    check("nor_flag", out_flag, 1'b1);
    check("nor_unit", out_unit, 2'b01);
    consume();

    run_op(4'b0000, 16'h1234, 16'h0001);
    check("add_data", out_data, 16'h1235);
    check("add_flag", out_flag, 1'b0);
    check("add_unit", out_unit, 2'b00);
    consume();

    run_op(4'b1000, 16'h0005, 16'h0005);
    check("cmp_data", out_data, 16'h0000);
    check("cmp_flag", out_flag, 1'b1);
    check("cmp_unit", out_unit, 2'b10);
    consume();

    // shift result doubles as the backpressure payload
    run_op(4'b1100, 16'h0001, 16'h0004);
    check("shl_data", out_data, 16'h0010);
    check("shl_unit", out_unit, 2'b11);
    held = 16'h0010;
    in_valid = 1'b1; in_fun = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_out_data", out_data, held);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_enables", ens(), 4'b0000);
    end
    in_valid = 1'b0;
    consume();

    // async reset while the op sits in CAPT
    in_valid = 1'b1; in_fun = 4'b0101; in_A = 16'h1111; in_B = 16'h2222;
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_A", A, 16'h0000);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst_out_valid", out_valid, 1'b0);
      check("postrst_enables", ens(), 4'b0000);
    end

    run_op(4'b0100, 16'hFF00, 16'h0FF0);
    check("and_data", out_data, 16'h0F00);
    check("and_flag", out_flag, 1'b1);
    check("and_unit", out_unit, 2'b01);
    consume();

    // streaming with out_ready and in_valid held high
    in_valid = 1'b1; out_ready = 1'b1; in_fun = 4'b0101; in_A = 16'h00F0; in_B = 16'h0F0F;
    for (int i = 0; i < 24; i++) begin
      if (in_ready) acc.push_back(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_accepts_min", (acc.size() >= 5) ? 1 : 0, 1);
    for (int i = 1; i < acc.size(); i++) begin
      check("stream_period", acc[i] - acc[i-1], period);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
